// File: rtl/seg_streamer.sv
// seg_streamer: buffers path points, pairs consecutive points into segments, strobes in_val once per segment.
// Latency 2 cycles from second point accepted to in_val; seg_ready low holds S_WAIT, pt_ready = !full.

module seg_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] wdat_i,
  input  logic         pop_i,
  output logic [W-1:0] rdat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdat_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + NW'(1);
      2'b01:   cnt_d = cnt_q - NW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdat_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module seg_streamer #(
  parameter int COORD_W = 8,
  parameter int DEPTH   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [COORD_W-1:0] pt_x,
  input  logic [COORD_W-1:0] pt_y,
  input  logic [COORD_W-1:0] pt_z,
  input  logic               pt_last,
  input  logic               seg_ready,
  output logic               in_val,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] z1,
  output logic [COORD_W-1:0] x2,
  output logic [COORD_W-1:0] y2,
  output logic [COORD_W-1:0] z2,
  output logic [7:0]         seg_id,
  output logic [7:0]         dropped,
  output logic               idle
);
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } xyz_t;

  typedef struct packed {
    xyz_t p;
    logic last;
  } pt_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  xyz_t       prev_q, prev_d;
  logic       have_prev_q, have_prev_d;
  xyz_t       seg_a_q, seg_a_d;
  xyz_t       seg_b_q, seg_b_d;
  logic       in_val_q, in_val_d;
  logic [7:0] seg_id_q, seg_id_d;
  logic [7:0] dropped_q, dropped_d;

  pt_t  wr_pt, head;
  logic fifo_full, fifo_empty, pop;

  assign wr_pt = '{p: '{x: pt_x, y: pt_y, z: pt_z}, last: pt_last};

  seg_fifo #(
    .W     ($bits(pt_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pt_valid),
    .wdat_i  (wr_pt),
    .pop_i   (pop),
    .rdat_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    seg_a_d     = seg_a_q;
    seg_b_d     = seg_b_q;
    in_val_d    = 1'b0;
    seg_id_d    = seg_id_q;
    dropped_d   = dropped_q;
    pop         = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (!have_prev_q) begin
            prev_d      = head.p;
            have_prev_d = !head.last;
            // A path that opens and closes on the same point has no segment.
            if (head.last && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;
          end else if (head.p == prev_q) begin
            have_prev_d = !head.last;
          end else begin
            seg_a_d     = prev_q;
            seg_b_d     = head.p;
            prev_d      = head.p;
            have_prev_d = !head.last;
            state_d     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (seg_ready) begin
          in_val_d = 1'b1;
          seg_id_d = seg_id_q + 8'd1;
          state_d  = S_PULSE;
        end
      end
      S_PULSE: begin
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      seg_a_q     <= '0;
      seg_b_q     <= '0;
      in_val_q    <= 1'b0;
      seg_id_q    <= '0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      seg_a_q     <= seg_a_d;
      seg_b_q     <= seg_b_d;
      in_val_q    <= in_val_d;
      seg_id_q    <= seg_id_d;
      dropped_q   <= dropped_d;
    end
  end

  assign pt_ready = !fifo_full;
  assign in_val   = in_val_q;
  assign x1       = seg_a_q.x;
  assign y1       = seg_a_q.y;
  assign z1       = seg_a_q.z;
  assign x2       = seg_b_q.x;
  assign y2       = seg_b_q.y;
  assign z2       = seg_b_q.z;
  assign seg_id   = seg_id_q;
  assign dropped  = dropped_q;
  assign idle     = fifo_empty && (state_q == S_FETCH) && !in_val_q;
endmodule

// File: tb/tb_seg_streamer.sv
// Directed bench for seg_streamer: point table with hand-derived segments plus latency, backpressure, wrap and reset sequences.
module tb_seg_streamer;
  localparam int CW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pt_valid = 1'b0;
  logic          pt_last = 1'b0;
  logic          seg_ready = 1'b1;
  logic [CW-1:0] pt_x = '0, pt_y = '0, pt_z = '0;
  logic          pt_ready, in_val, idle;
  logic [CW-1:0] x1, y1, z1, x2, y2, z2;
  logic [7:0]    seg_id, dropped;

  seg_streamer #(.COORD_W(CW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_last(pt_last),
    .seg_ready(seg_ready), .in_val(in_val),
    .x1(x1), .y1(y1), .z1(z1), .x2(x2), .y2(y2), .z2(z2),
    .seg_id(seg_id), .dropped(dropped), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int x1, y1, z1, x2, y2, z2, id, cyc;
  } strobe_t;

  typedef struct {
    int px, py, pz, last, emit, ex, ey, ez, id;
  } vec_t;

  strobe_t sq[$];
  logic    in_val_prev = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (in_val) begin
      check("in_val_single_cycle", int'(in_val_prev), 0);
      sq.push_back('{int'(x1), int'(y1), int'(z1), int'(x2), int'(y2), int'(z2), int'(seg_id), cyc});
    end
    in_val_prev = in_val;
  end

  function automatic strobe_t st(input int i);
    strobe_t s;
    s = '{-1, -1, -1, -1, -1, -1, -1, -1};
    if (i >= 0 && i < sq.size()) s = sq[i];
    return s;
  endfunction

  task automatic apply_reset();
    pt_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic push_pt(input int x, input int y, input int z, input int last, output int acc);
    int n;
    n = 0;
    pt_x = x[CW-1:0];
    pt_y = y[CW-1:0];
    pt_z = z[CW-1:0];
    pt_last = (last != 0);
    pt_valid = 1'b1;
    while (!pt_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pt_ready) check("push_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
    end
    acc = cyc;
    pt_valid = 1'b0;
  endtask

  task automatic drain(input int n, input string name);
    int t;
    t = 0;
    while ((sq.size() < n || !idle) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain_in_time"}, int'(t < 5000), 1);
    repeat (8) @(negedge clk);
    check({name, "_strobe_count"}, sq.size(), n);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_val"}, in_val, 0);
    check({tag, "_x1"}, x1, 0);
    check({tag, "_y1"}, y1, 0);
    check({tag, "_z1"}, z1, 0);
    check({tag, "_x2"}, x2, 0);
    check({tag, "_y2"}, y2, 0);
    check({tag, "_z2"}, z2, 0);
    check({tag, "_seg_id"}, seg_id, 0);
    check({tag, "_dropped"}, dropped, 0);
    check({tag, "_idle"}, idle, 1);
    check({tag, "_pt_ready"}, pt_ready, 1);
  endtask

  initial begin
    vec_t    v[17];
    strobe_t s;
    int      k, j;

    // px py pz last | emit x1 y1 z1 id  (x2..z2 = this point)
    v[0]  = '{1,   1,   1,   0, 0, 0,   0,  0,   0};
    v[1]  = '{2,   1,   1,   0, 1, 1,   1,  1,   1};
    v[2]  = '{2,   3,   1,   0, 1, 2,   1,  1,   2};
    v[3]  = '{2,   3,   5,   0, 1, 2,   3,  1,   3};
    v[4]  = '{7,   3,   5,   1, 1, 2,   3,  5,   4};
    v[5]  = '{50,  60,  70,  0, 0, 0,   0,  0,   0};
    v[6]  = '{51,  60,  70,  0, 1, 50,  60, 70,  5};
    v[7]  = '{51,  62,  70,  1, 1, 51,  60, 70,  6};
    v[8]  = '{4,   4,   4,   0, 0, 0,   0,  0,   0};
    v[9]  = '{4,   4,   4,   0, 0, 0,   0,  0,   0};
    v[10] = '{9,   9,   9,   1, 1, 4,   4,  4,   7};
    v[11] = '{200, 100, 33,  1, 0, 0,   0,  0,   0};
    v[12] = '{255, 0,   255, 0, 0, 0,   0,  0,   0};
    v[13] = '{0,   255, 0,   1, 1, 255, 0,  255, 8};
    v[14] = '{5,   5,   5,   0, 0, 0,   0,  0,   0};
    v[15] = '{5,   5,   5,   1, 0, 0,   0,  0,   0};
    v[16] = '{6,   6,   6,   1, 0, 0,   0,  0,   0};

    // Reset state and single-segment latency.
    apply_reset();
    @(negedge clk);
    check_reset_state("rst");
    sq.delete();
    push_pt(1, 2, 3, 0, k);
    push_pt(10, 20, 30, 1, k);
    drain(1, "basic");
    s = st(0);
    check("basic_x1", s.x1, 1);
    check("basic_y1", s.y1, 2);
    check("basic_z1", s.z1, 3);
    check("basic_x2", s.x2, 10);
    check("basic_y2", s.y2, 20);
    check("basic_z2", s.z2, 30);
    check("basic_id", s.id, 1);
    check("basic_latency", s.cyc - k, 2);
    check("basic_idle_after", idle, 1);

    // Table: two paths, zero-length point, lone points, closing duplicate.
    apply_reset();
    sq.delete();
    for (int i = 0; i < 17; i++) push_pt(v[i].px, v[i].py, v[i].pz, v[i].last, k);
    drain(8, "table");
    j = 0;
    for (int i = 0; i < 17; i++) begin
      if (v[i].emit != 0) begin
        s = st(j);
        check($sformatf("tbl%0d_x1", i), s.x1, v[i].ex);
        check($sformatf("tbl%0d_y1", i), s.y1, v[i].ey);
        check($sformatf("tbl%0d_z1", i), s.z1, v[i].ez);
        check($sformatf("tbl%0d_x2", i), s.x2, v[i].px);
        check($sformatf("tbl%0d_y2", i), s.y2, v[i].py);
        check($sformatf("tbl%0d_z2", i), s.z2, v[i].pz);
        check($sformatf("tbl%0d_id", i), s.id, v[i].id);
        if (j > 0) check($sformatf("tbl%0d_spacing_ge3", i), int'(s.cyc - st(j - 1).cyc >= 3), 1);
        j++;
      end
    end
    check("tbl_dropped", dropped, 2);
    check("tbl_seg_id", seg_id, 8);

    // Backpressure: DEPTH+2 points with seg_ready low fill the FIFO.
    apply_reset();
    sq.delete();
    seg_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) push_pt(i + 1, 2 * i, 3, int'(i == DEPTH + 1), k);
    @(negedge clk);
    check("bp_pt_ready_full", pt_ready, 0);
    check("bp_x1", x1, 1);
    check("bp_y1", y1, 0);
    check("bp_x2", x2, 2);
    check("bp_y2", y2, 2);
    repeat (20) @(negedge clk);
    check("bp_held_x1", x1, 1);
    check("bp_held_x2", x2, 2);
    check("bp_held_z2", z2, 3);
    check("bp_no_strobe", sq.size(), 0);
    check("bp_still_full", pt_ready, 0);
    seg_ready = 1'b1;
    @(negedge clk);
    check("bp_release_strobe", in_val, 1);
    @(negedge clk);
    check("bp_ready_before_pop", pt_ready, 0);
    @(negedge clk);
    check("bp_ready_after_pop", pt_ready, 1);
    drain(DEPTH + 1, "bp");
    for (int i = 0; i < DEPTH + 1; i++) begin
      s = st(i);
      check($sformatf("bp%0d_x1", i), s.x1, i + 1);
      check($sformatf("bp%0d_y1", i), s.y1, 2 * i);
      check($sformatf("bp%0d_x2", i), s.x2, i + 2);
      check($sformatf("bp%0d_y2", i), s.y2, 2 * i + 2);
      check($sformatf("bp%0d_id", i), s.id, i + 1);
    end

    // seg_id wrap over 256 segments.
    apply_reset();
    sq.delete();
    for (int i = 0; i < 257; i++) push_pt(i % 256, i / 256, 7, int'(i == 256), k);
    drain(256, "wrap");
    check("wrap_first_id", st(0).id, 1);
    check("wrap_id_255", st(254).id, 255);
    check("wrap_id_0", st(255).id, 0);
    check("wrap_seg_id_out", seg_id, 0);
    check("wrap_last_x2", st(255).x2, 0);
    check("wrap_last_y2", st(255).y2, 1);

    // Lone points: dropped saturates, no strobes, seg_id unchanged.
    sq.delete();
    for (int i = 0; i < 300; i++) push_pt(i % 256, 1, 1, 1, k);
    repeat (10) @(negedge clk);
    check("drop_saturate", dropped, 255);
    check("drop_no_strobe", sq.size(), 0);
    check("drop_seg_id", seg_id, 0);

    // Reset while in_val is high with four points buffered.
    apply_reset();
    sq.delete();
    seg_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_pt(3 * i + 1, 5, 5, int'(i == 5), k);
    @(posedge clk); #1;
    check("mid_not_idle", idle, 0);
    seg_ready = 1'b1;
    @(posedge clk); #1;
    check("mid_in_val_high", in_val, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_in_val_cleared", in_val, 0);
    @(negedge clk);
    check_reset_state("mid");
    sq.delete();
    repeat (30) @(negedge clk);
    check("mid_no_old_strobes", sq.size(), 0);
    check("mid_idle", idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
